sobel_edge_stream: RTL

Streaming 3x3 Sobel edge detector for the VGA pixel path. It sits between the pixel source and the VGA output mux.
- Buffers the two previous lines internally and builds a full 3x3 window per accepted pixel.
- Computes |Gx|+|Gy| per pixel.
- Emits either the clamped magnitude or a thresholded binary edge map, selectable per pixel.
- Generalises the earlier single-column gradient block: parametrised width and line length, true 2-D kernel, valid/sof framing, runtime mode and threshold.

---
 rtl/sobel_pkg.sv | 16 +
 rtl/sobel_line_buffer.sv | 19 +
 rtl/sobel_edge_stream.sv | 116 +++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared encodings, kernel weights and width helpers for the Sobel edge stream.
package sobel_pkg;
  localparam logic MODE_BIN = 1'b0;
  localparam logic MODE_MAG = 1'b1;
  localparam int K_SIDE = 1;
  localparam int K_MID = 2;
  localparam int PIX_W_DEF = 8;
  function automatic int grad_w(input int pix_w);
    return pix_w + 3;
  endfunction
  function automatic int mag_w(input int pix_w);
    return pix_w + 4;
  endfunction
  localparam int GRAD_W_DEF = grad_w(PIX_W_DEF);
  localparam int MAG_W_DEF = mag_w(PIX_W_DEF);
endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: one-line simple dual-port RAM, registered read returns old data on same-address write.
module sobel_line_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 640,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             VGA_CLK,
  input  logic             i_we,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge VGA_CLK) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
    o_rd_data <= r_mem[i_rd_addr];
  end
endmodule

// File: rtl/sobel_edge_stream.sv
// sobel_edge_stream: streaming 3x3 Sobel |Gx|+|Gy| with clamped or thresholded output.
// Three-stage fixed-latency pipeline: line-buffer read, window shift, gradient and output register.
module sobel_edge_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int H_ACTIVE = 640
) (
  input  logic             VGA_CLK,
  input  logic             RST,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_sof,
  input  logic             mode,
  input  logic [PIX_W-1:0] threshold,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_data,
  output logic             out_sof
);
  localparam int GRAD_W = grad_w(PIX_W);
  localparam int MAG_W = mag_w(PIX_W);
  localparam int CW = $clog2(H_ACTIVE);
  localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
  logic [CW-1:0] r_col, w_col, r_col1;
  logic [1:0] r_row, w_row;
  logic w_wrap;
  logic [PIX_W-1:0] w_b0, w_b1, r_pix1;
  logic r_v1, r_sof1, r_brd1, r_v2, r_sof2, r_brd2;
  logic [PIX_W-1:0] r_win [3][3];
  logic signed [GRAD_W-1:0] w_gx, w_gy;
  logic [GRAD_W-1:0] w_ax, w_ay;
  logic [MAG_W-1:0] w_mag;
  logic [PIX_W-1:0] w_sat, w_bin, w_res;
  // A sof pixel is placed at the origin regardless of where the counters were.
  assign w_col = pix_sof ? '0 : r_col;
  assign w_row = pix_sof ? 2'd0 : r_row;
  assign w_wrap = w_col == COL_LAST;
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      r_col <= '0;
      r_row <= 2'd0;
    end else if (pix_valid) begin
      r_col <= w_wrap ? '0 : w_col + 1'b1;
      r_row <= (w_wrap && w_row != 2'd2) ? w_row + 2'd1 : w_row;
    end
  end
  sobel_line_buffer #(.WIDTH(PIX_W), .DEPTH(H_ACTIVE)) u_lb0 (
    .VGA_CLK(VGA_CLK), .i_we(pix_valid), .i_wr_addr(w_col), .i_wr_data(pix_data),
    .i_rd_addr(w_col), .o_rd_data(w_b0)
  );
  // Buffer 1 takes buffer 0's old line one cycle later, at the column captured in S1.
  sobel_line_buffer #(.WIDTH(PIX_W), .DEPTH(H_ACTIVE)) u_lb1 (
    .VGA_CLK(VGA_CLK), .i_we(r_v1), .i_wr_addr(r_col1), .i_wr_data(w_b0),
    .i_rd_addr(w_col), .o_rd_data(w_b1)
  );
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      r_v1 <= 1'b0;
      r_sof1 <= 1'b0;
      r_brd1 <= 1'b0;
      r_pix1 <= '0;
      r_col1 <= '0;
    end else begin
      r_v1 <= pix_valid;
      r_sof1 <= pix_valid & pix_sof;
      r_brd1 <= w_row < 2'd2 || w_col < CW'(2);
      r_pix1 <= pix_data;
      r_col1 <= w_col;
    end
  end
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      r_win <= '{default: '{default: '0}};
      r_v2 <= 1'b0;
      r_sof2 <= 1'b0;
      r_brd2 <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      r_sof2 <= r_sof1;
      r_brd2 <= r_brd1;
      if (r_v1) begin
        for (int i = 0; i < 3; i++) begin
          r_win[i][0] <= r_win[i][1];
          r_win[i][1] <= r_win[i][2];
        end
        r_win[0][2] <= w_b1;
        r_win[1][2] <= w_b0;
        r_win[2][2] <= r_pix1;
      end
    end
  end
  function automatic logic signed [GRAD_W-1:0] wsum(input logic [PIX_W-1:0] a, b, c);
    logic [GRAD_W-1:0] s;
    s = GRAD_W'(a) * GRAD_W'(K_SIDE) + GRAD_W'(b) * GRAD_W'(K_MID) + GRAD_W'(c) * GRAD_W'(K_SIDE);
    return signed'(s);
  endfunction
  assign w_gx = wsum(r_win[0][2], r_win[1][2], r_win[2][2]) - wsum(r_win[0][0], r_win[1][0], r_win[2][0]);
  assign w_gy = wsum(r_win[2][0], r_win[2][1], r_win[2][2]) - wsum(r_win[0][0], r_win[0][1], r_win[0][2]);
  assign w_ax = w_gx[GRAD_W-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
  assign w_ay = w_gy[GRAD_W-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
  assign w_mag = MAG_W'(w_ax) + MAG_W'(w_ay);
  assign w_sat = |w_mag[MAG_W-1:PIX_W] ? '1 : w_mag[PIX_W-1:0];
  assign w_bin = w_mag > MAG_W'(threshold) ? '1 : '0;
  assign w_res = r_brd2 ? '0 : mode == MODE_MAG ? w_sat : mode == MODE_BIN ? w_bin : '0;
  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      out_valid <= 1'b0;
      out_sof <= 1'b0;
      out_data <= '0;
    end else begin
      out_valid <= r_v2;
      out_sof <= r_sof2;
      if (r_v2) out_data <= w_res;
    end
  end
endmodule
